spike_vote_counter: RTL and testbench

SPIKE_VOTE_COUNTER -- requirements
Module: spike_vote_counter

---
 rtl/snn_pkg.sv | 15 +
 rtl/spike_counter_cell.sv | 38 +++
 rtl/spike_vote_counter.sv | 141 ++++++++++++++
 tb/tb_spike_vote_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared state encoding and default sizes for the spike vote counter
package snn_pkg;

  // Default macro-group geometry
  localparam int SNN_NUM_NEURON = 16;
  localparam int SNN_CNT_W      = 8;

  // Vote counter control states
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } svc_state_e;

endpackage

// File: rtl/spike_counter_cell.sv
// rtl/spike_counter_cell.sv - one per-neuron spike counter; SPIKE_VOTE_SAT_EN selects saturate vs wrap
module spike_counter_cell
  import snn_pkg::*;
#(
  parameter int CNT_W = SNN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

`ifdef SPIKE_VOTE_SAT_EN
  // Hold at all-ones once the counter is full
  assign w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
`else
  // Plain modulo-2^CNT_W increment
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
`endif

  // Counter register: clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/spike_vote_counter.sv
// rtl/spike_vote_counter.sv - per-neuron spike vote with sequential argmax; SPIKE_VOTE_SAT_EN enables counter saturation
module spike_vote_counter
  import snn_pkg::*;
#(
  parameter int NUM_NEURON = SNN_NUM_NEURON,
  parameter int CNT_W      = SNN_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_NEURON-1:0]         spike_i,
  input  logic                          spike_valid,
  input  logic                          picture_done,
  output logic                          busy,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [$clog2(NUM_NEURON)-1:0] class_o,
  output logic [CNT_W-1:0]              class_cnt,
  output logic                          no_spike
);

  localparam int IDX_W = $clog2(NUM_NEURON);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);

  svc_state_e r_state;
  svc_state_e w_state_nxt;

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_cnt;
  logic [IDX_W-1:0] r_class;
  logic [CNT_W-1:0] r_class_cnt;
  logic             r_no_spike;

  logic [CNT_W-1:0] w_cnt [NUM_NEURON];
  logic             w_accept;
  logic             w_scan_last;
  logic [CNT_W-1:0] w_cur;
  logic             w_take;
  logic [IDX_W-1:0] w_win_idx;
  logic [CNT_W-1:0] w_win_cnt;

  // Spikes only count while accumulating; the final scan step clears every counter
  assign w_accept    = (r_state == ACCUM) && spike_valid;
  assign w_scan_last = (r_state == SCAN) && (r_idx == LAST_IDX);

  for (genvar g = 0; g < NUM_NEURON; g++) begin : g_cell
    spike_counter_cell #(
      .CNT_W (CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_accept & spike_i[g]),
      .i_clr (w_scan_last),
      .o_cnt (w_cnt[g])
    );
  end

  // Strict greater-than keeps the earliest (lowest) index on ties
  assign w_cur     = w_cnt[r_idx];
  assign w_take    = w_cur > r_best_cnt;
  assign w_win_idx = w_take ? r_idx : r_best_idx;
  assign w_win_cnt = w_take ? w_cur : r_best_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        if (picture_done) begin
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (w_scan_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  // Scan pointer, running best, and the latched result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_class     <= '0;
      r_class_cnt <= '0;
      r_no_spike  <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (picture_done) begin
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
          end
        end
        SCAN: begin
          r_idx      <= r_idx + IDX_W'(1);
          r_best_idx <= w_win_idx;
          r_best_cnt <= w_win_cnt;
          if (w_scan_last) begin
            r_class     <= w_win_idx;
            r_class_cnt <= w_win_cnt;
            r_no_spike  <= (w_win_cnt == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign class_o   = r_class;
  assign class_cnt = r_class_cnt;
  assign no_spike  = r_no_spike;

endmodule

// File: tb/tb_spike_vote_counter.sv
// tb/tb_spike_vote_counter.sv - self-checking bench for spike_vote_counter
module tb_spike_vote_counter;

  localparam int N   = 16;
  localparam int CW  = 8;
  localparam int LAT = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  spike_i;
  logic          spike_valid;
  logic          picture_done;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [3:0]    class_o;
  logic [CW-1:0] class_cnt;
  logic          no_spike;

  int n_vec;
  int n_miss;
  int mcnt [N];

  typedef struct {
    int          nstrobe;
    logic [15:0] mask;
    bit          same;
    int          exp_class;
    int          exp_cnt;
    int          exp_nos;
  } vec_t;

  vec_t vec [6];

  spike_vote_counter #(
    .NUM_NEURON (N),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spike_i      (spike_i),
    .spike_valid  (spike_valid),
    .picture_done (picture_done),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .class_o      (class_o),
    .class_cnt    (class_cnt),
    .no_spike     (no_spike)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs applied at a falling edge, held across one rising edge
  task automatic cycle(input logic sv, input logic [15:0] sp, input logic pd, input logic rr);
    spike_valid  = sv;
    spike_i      = sp;
    picture_done = pd;
    result_ready = rr;
    @(negedge clk);
    spike_valid  = 1'b0;
    spike_i      = '0;
    picture_done = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic m_strobe(input logic [15:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
`ifdef SPIKE_VOTE_SAT_EN
        mcnt[i] = (mcnt[i] + 1 > 255) ? 255 : mcnt[i] + 1;
`else
        mcnt[i] = (mcnt[i] + 1) % 256;
`endif
      end
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
  endtask

  // Winner = first index holding the maximum count
  task automatic m_expect(output int c, output int n, output int nos);
    int maxv;
    maxv = 0;
    for (int i = 0; i < N; i++) if (mcnt[i] > maxv) maxv = mcnt[i];
    c = -1;
    for (int i = 0; i < N; i++) if (c < 0 && mcnt[i] == maxv) c = i;
    n   = maxv;
    nos = (maxv == 0) ? 1 : 0;
  endtask

  // Called right after the edge that sampled picture_done
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    chk({tag, "_busy_scan"}, int'(busy), 1);
    while (!result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, LAT);
  endtask

  task automatic finish_picture(input string tag, input int ec, input int en, input int enos, input int hold);
    wait_result(tag);
    chk({tag, "_class"}, int'(class_o), ec);
    chk({tag, "_cnt"}, int'(class_cnt), en);
    chk({tag, "_nospike"}, int'(no_spike), enos);
    for (int h = 0; h < hold; h++) cycle(1'b0, '0, 1'b0, 1'b0);
    if (hold > 0) chk({tag, "_held_cls"}, int'(class_o), ec);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk({tag, "_rv_drop"}, int'(result_valid), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
    m_clear();
  endtask

  initial begin
    int ec, en, enos, ns;
    logic [15:0] mask;

    n_vec  = 0;
    n_miss = 0;
    m_clear();

    vec[0] = '{nstrobe: 5,   mask: 16'h0008, same: 1'b0, exp_class: 3,  exp_cnt: 5, exp_nos: 0};
    vec[1] = '{nstrobe: 4,   mask: 16'h0204, same: 1'b0, exp_class: 2,  exp_cnt: 4, exp_nos: 0};
    vec[2] = '{nstrobe: 0,   mask: 16'h0000, same: 1'b0, exp_class: 0,  exp_cnt: 0, exp_nos: 1};
    vec[3] = '{nstrobe: 2,   mask: 16'h8000, same: 1'b1, exp_class: 15, exp_cnt: 3, exp_nos: 0};
    vec[4] = '{nstrobe: 3,   mask: 16'hFFFF, same: 1'b0, exp_class: 0,  exp_cnt: 3, exp_nos: 0};
`ifdef SPIKE_VOTE_SAT_EN
    vec[5] = '{nstrobe: 300, mask: 16'h0001, same: 1'b0, exp_class: 0,  exp_cnt: 255, exp_nos: 0};
`else
    vec[5] = '{nstrobe: 300, mask: 16'h0001, same: 1'b0, exp_class: 0,  exp_cnt: 44, exp_nos: 0};
`endif

    rst_n        = 1'b0;
    spike_i      = '0;
    spike_valid  = 1'b0;
    picture_done = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rv", int'(result_valid), 0);
    chk("rst_class", int'(class_o), 0);
    chk("rst_cnt", int'(class_cnt), 0);
    chk("rst_nospike", int'(no_spike), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven pictures
    for (int t = 0; t < 6; t++) begin
      for (int s = 0; s < vec[t].nstrobe; s++) begin
        cycle(1'b1, vec[t].mask, 1'b0, 1'b0);
        m_strobe(vec[t].mask);
      end
      if (vec[t].same) begin
        cycle(1'b1, vec[t].mask, 1'b1, 1'b0);
        m_strobe(vec[t].mask);
      end else begin
        cycle(1'b0, '0, 1'b1, 1'b0);
      end
      finish_picture($sformatf("vec%0d", t), vec[t].exp_class, vec[t].exp_cnt, vec[t].exp_nos, 0);
    end

    // Empty picture, long back-pressure, then next picture starts from zero
    cycle(1'b0, '0, 1'b1, 1'b0);
    wait_result("hold");
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk($sformatf("hold%0d_rv", k), int'(result_valid), 1);
      chk($sformatf("hold%0d_busy", k), int'(busy), 1);
      chk($sformatf("hold%0d_state", k), int'({no_spike, class_o, class_cnt}), int'({1'b1, 4'd0, 8'd0}));
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("hold_rv_drop", int'(result_valid), 0);
    chk("hold_busy_drop", int'(busy), 0);
    cycle(1'b1, 16'h0040, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    finish_picture("after_hold", 6, 1, 0, 0);

    // Strobes and picture_done while busy must be ignored
    repeat (3) cycle(1'b1, 16'h0010, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    begin
      int lat;
      lat = 0;
      while (!result_valid && lat < 40) begin
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        lat++;
      end
      chk("noise_latency", lat, LAT);
    end
    chk("noise_class", int'(class_o), 4);
    chk("noise_cnt", int'(class_cnt), 3);
    repeat (3) cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
    chk("noise_done_rv", int'(result_valid), 1);
    chk("noise_done_cnt", int'(class_cnt), 3);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("noise_rv_drop", int'(result_valid), 0);

    // Reset in the middle of a scan
    repeat (2) cycle(1'b1, 16'h0002, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (7) cycle(1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rv", int'(result_valid), 0);
    chk("midrst_class", int'(class_o), 0);
    chk("midrst_cnt", int'(class_cnt), 0);
    chk("midrst_nospike", int'(no_spike), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    cycle(1'b0, '0, 1'b1, 1'b0);
    finish_picture("midrst_zero", 0, 0, 1, 0);

    // Randomized pictures against the reference model
    for (int p = 0; p < 12; p++) begin
      ns = $urandom_range(0, 30);
      for (int s = 0; s < ns; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          cycle(1'b0, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        end else begin
          mask = 16'($urandom & $urandom);
          cycle(1'b1, mask, 1'b0, 1'($urandom_range(0, 1)));
          m_strobe(mask);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        mask = 16'($urandom & $urandom);
        cycle(1'b1, mask, 1'b1, 1'b0);
        m_strobe(mask);
      end else begin
        cycle(1'b0, '0, 1'b1, 1'b0);
      end
      m_expect(ec, en, enos);
      finish_picture($sformatf("rnd%0d", p), ec, en, enos, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
